i2s_txrx: RTL and testbench

Master-mode I2S transceiver: one shared timing generator produces the bit clock (`sck`) and word select (`ws`) from the system clock. It drives a 24-bit stereo transmit stream and captures a 24-bit stereo receive stream in the same frame timing. It sits between the audio datapath (parallel samples) and the codec/serial pins. With `sd_out` looped to `sd_in`, the received words equal the transmitted words.

---
 rtl/i2s_txrx.sv | 139 +++++++++++++
 tb/tb_i2s_txrx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_txrx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_txrx
// Description : Master-mode I2S transceiver. A single divider/slot counter
//               pair generates sck and ws from clk. The same timing drives
//               a 24-bit stereo transmitter and a 24-bit stereo receiver,
//               so sd_out looped back to sd_in returns the transmitted words.
//
// Ports       : clk          system clock, all logic on rising edge
//               rst_n        synchronous active-low reset
//               i_tx_left    left sample, captured on o_tx_load cycles
//               i_tx_right   right sample, captured on o_tx_load cycles
//               o_tx_load    one-cycle pulse at the start of every frame
//               o_sck        I2S bit clock (CLK_DIV clk per period)
//               o_ws         word select, 0 = left, 1 = right
//               o_sd_out     serial transmit data
//               i_sd_in      serial receive data
//               o_rx_left    last received left word
//               o_rx_right   last received right word
//               o_rx_dump    one-cycle pulse, rx words updated this cycle
//
// Parameters  : CLK_DIV      clk cycles per sck period, even and >= 2
//
// Revision    : 1.0  initial release
// ============================================================================
module i2s_txrx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] i_tx_left,
    input  logic [23:0] i_tx_right,
    output logic        o_tx_load,
    output logic        o_sck,
    output logic        o_ws,
    output logic        o_sd_out,
    input  logic        i_sd_in,
    output logic [23:0] o_rx_left,
    output logic [23:0] o_rx_right,
    output logic        o_rx_dump
);

    localparam int                 c_div_w    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV / 2);
    localparam logic [5:0]         c_last_rx  = 6'd56;

    // Timing state
    logic [c_div_w-1:0] r_div_cnt;
    logic [5:0]         r_bit_cnt;

    // Transmit shadow words and receive shift registers
    logic [23:0] r_shadow_l;
    logic [23:0] r_shadow_r;
    logic [23:0] r_shift_l;
    logic [23:0] r_shift_r;

    // Receive outputs
    logic [23:0] r_rx_left;
    logic [23:0] r_rx_right;
    logic        r_rx_dump;

    logic       w_div_wrap;
    logic       w_sample;
    logic [4:0] w_slot_lo;
    logic       w_data_slot;
    logic [4:0] w_bit_idx;
    logic       w_tx_load;
    logic       w_tx_bit;

    assign w_div_wrap = (r_div_cnt == c_div_last);
    // Receive sample point is mid-slot, right after sck rises.
    assign w_sample   = (r_div_cnt == c_div_half);

    // Both channels use the same position within their half-frame:
    // slots 1..24 (left) and 33..56 (right) share the low five bits 1..24,
    // and the transmitted bit index is 24 minus that position (MSB first).
    assign w_slot_lo   = r_bit_cnt[4:0];
    assign w_data_slot = (w_slot_lo != 5'd0) && (w_slot_lo <= 5'd24);
    assign w_bit_idx   = 5'd24 - w_slot_lo;

    // The counters sit at zero while reset is held, so the frame-start
    // decode is qualified with rst_n to keep the pulse quiet during reset
    // and still present in the first cycle after release.
    assign w_tx_load = rst_n && (r_div_cnt == '0) && (r_bit_cnt == 6'd0);

    assign w_tx_bit = r_bit_cnt[5] ? r_shadow_r[w_bit_idx] : r_shadow_l[w_bit_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= 6'd0;
            r_shadow_l <= 24'd0;
            r_shadow_r <= 24'd0;
            r_shift_l  <= 24'd0;
            r_shift_r  <= 24'd0;
            r_rx_left  <= 24'd0;
            r_rx_right <= 24'd0;
            r_rx_dump  <= 1'b0;
        end else begin
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + c_div_w'(1);
            if (w_div_wrap) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end

            if (w_tx_load) begin
                r_shadow_l <= i_tx_left;
                r_shadow_r <= i_tx_right;
            end

            if (w_sample && w_data_slot) begin
                if (!r_bit_cnt[5]) begin
                    r_shift_l <= {r_shift_l[22:0], i_sd_in};
                end else begin
                    r_shift_r <= {r_shift_r[22:0], i_sd_in};
                end
            end

            // The last right bit is folded in directly so the dump happens
            // on the same edge that samples it.
            r_rx_dump <= 1'b0;
            if (w_sample && (r_bit_cnt == c_last_rx)) begin
                r_rx_left  <= r_shift_l;
                r_rx_right <= {r_shift_r[22:0], i_sd_in};
                r_rx_dump  <= 1'b1;
            end
        end
    end

    assign o_tx_load  = w_tx_load;
    assign o_sck      = (r_div_cnt >= c_div_half);
    assign o_ws       = r_bit_cnt[5];
    assign o_sd_out   = w_data_slot ? w_tx_bit : 1'b0;
    assign o_rx_left  = r_rx_left;
    assign o_rx_right = r_rx_right;
    assign o_rx_dump  = r_rx_dump;

endmodule
`default_nettype wire

// File: tb/tb_i2s_txrx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_txrx
// Description : Self-checking bench for i2s_txrx. One instance runs with
//               CLK_DIV=4 and one with CLK_DIV=8, each with sd_out looped
//               to sd_in. Expected waveforms and received words come from a
//               frame/slot reference model built from the I2S timing rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_i2s_txrx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n4, rst_n8;
    logic [23:0] tx_l4, tx_r4, tx_l8, tx_r8;
    logic        load4, sck4, ws4, sd4, dump4;
    logic        load8, sck8, ws8, sd8, dump8;
    logic [23:0] rxl4, rxr4, rxl8, rxr8;

    int total = 0;
    int bad   = 0;

    i2s_txrx #(.CLK_DIV(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n4),
        .i_tx_left  (tx_l4),
        .i_tx_right (tx_r4),
        .o_tx_load  (load4),
        .o_sck      (sck4),
        .o_ws       (ws4),
        .o_sd_out   (sd4),
        .i_sd_in    (sd4),
        .o_rx_left  (rxl4),
        .o_rx_right (rxr4),
        .o_rx_dump  (dump4)
    );

    i2s_txrx #(.CLK_DIV(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n8),
        .i_tx_left  (tx_l8),
        .i_tx_right (tx_r8),
        .o_tx_load  (load8),
        .o_sck      (sck8),
        .o_ws       (ws8),
        .o_sd_out   (sd8),
        .i_sd_in    (sd8),
        .o_rx_left  (rxl8),
        .o_rx_right (rxr8),
        .o_rx_dump  (dump8)
    );

    // Reference: which bit of the frame's loaded words appears on the line
    // at cycle c of a frame-aligned run with divider d.
    function automatic logic model_sd(int d, int c, logic [23:0] l, logic [23:0] r);
        int k;
        k = (c / d) % 64;
        if (k >= 1 && k <= 24)  return l[24 - k];
        if (k >= 33 && k <= 56) return r[56 - k];
        return 1'b0;
    endfunction

    // Leaves the bench 1 time unit into cycle 0 of the new run.
    task automatic reset4();
        rst_n4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n4 = 1'b1;
    endtask

    task automatic test_reset();
        logic [57:0] got4, got8;
        rst_n4 = 1'b0;
        rst_n8 = 1'b0;
        tx_l4 = $urandom; tx_r4 = $urandom;
        tx_l8 = $urandom; tx_r8 = $urandom;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            got4 = {load4, sck4, ws4, sd4, dump4, rxl4, rxr4};
            got8 = {load8, sck8, ws8, sd8, dump8, rxl8, rxr8};
            total++;
            if (got4 !== 58'd0) begin
                bad++;
                $display("FAIL reset_outputs_div4 cyc=%0d got=%h exp=0", i, got4);
            end
            total++;
            if (got8 !== 58'd0) begin
                bad++;
                $display("FAIL reset_outputs_div8 cyc=%0d got=%h exp=0", i, got8);
            end
            tx_l4 = $urandom; tx_r4 = $urandom;
            @(posedge clk);
        end
    endtask

    // mode 0: fixed words; mode 1: tx_left changes at cycle 100;
    // mode 2: random words changing at random cycles.
    task automatic test_stream(input int ncyc, input int mode);
        logic [23:0] fl [0:15];
        logic [23:0] fr [0:15];
        logic [23:0] exp_rl, exp_rr;
        logic        e_sck, e_ws, e_load, e_dump, e_sd;
        int          f;
        exp_rl = 24'd0;
        exp_rr = 24'd0;
        if (mode == 2) begin
            tx_l4 = $urandom; tx_r4 = $urandom;
        end else begin
            tx_l4 = 24'hE3E3E3; tx_r4 = 24'h800001;
        end
        reset4();
        for (int c = 0; c < ncyc; c++) begin
            if (mode == 1 && c == 100) tx_l4 = 24'h123456;
            if (mode == 2 && $urandom_range(0, 49) == 0) begin
                tx_l4 = $urandom; tx_r4 = $urandom;
            end
            f = c / 256;
            if (c % 256 == 0) begin
                fl[f] = tx_l4;
                fr[f] = tx_r4;
            end
            #1;
            e_sck  = (c % 4) >= 2;
            e_ws   = ((c / 4) % 64) >= 32;
            e_load = (c % 256) == 0;
            e_dump = (c % 256) == 227;
            e_sd   = model_sd(4, c, fl[f], fr[f]);
            if (e_dump) begin
                exp_rl = fl[f];
                exp_rr = fr[f];
            end
            total++;
            if (sck4 !== e_sck) begin
                bad++; $display("FAIL sck m%0d c=%0d got=%b exp=%b", mode, c, sck4, e_sck);
            end
            total++;
            if (ws4 !== e_ws) begin
                bad++; $display("FAIL ws m%0d c=%0d got=%b exp=%b", mode, c, ws4, e_ws);
            end
            total++;
            if (load4 !== e_load) begin
                bad++; $display("FAIL tx_load m%0d c=%0d got=%b exp=%b", mode, c, load4, e_load);
            end
            total++;
            if (sd4 !== e_sd) begin
                bad++; $display("FAIL sd_out m%0d c=%0d got=%b exp=%b", mode, c, sd4, e_sd);
            end
            total++;
            if (dump4 !== e_dump) begin
                bad++; $display("FAIL rx_dump m%0d c=%0d got=%b exp=%b", mode, c, dump4, e_dump);
            end
            total++;
            if (rxl4 !== exp_rl) begin
                bad++; $display("FAIL rx_left m%0d c=%0d got=%h exp=%h", mode, c, rxl4, exp_rl);
            end
            total++;
            if (rxr4 !== exp_rr) begin
                bad++; $display("FAIL rx_right m%0d c=%0d got=%h exp=%h", mode, c, rxr4, exp_rr);
            end
            if (mode == 1 && c == 227) begin
                total++;
                if (rxl4 !== 24'hE3E3E3) begin
                    bad++; $display("FAIL frame0_left c=%0d got=%h exp=e3e3e3", c, rxl4);
                end
            end
            if (mode == 1 && c == 483) begin
                total++;
                if (rxl4 !== 24'h123456) begin
                    bad++; $display("FAIL frame1_left c=%0d got=%h exp=123456", c, rxl4);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] w2l, w2r, exp_rl, exp_rr;
        logic [57:0] got;
        logic        e_load, e_dump;
        tx_l4 = $urandom; tx_r4 = $urandom;
        reset4();
        repeat (150) @(posedge clk);
        #1;
        rst_n4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            got = {load4, sck4, ws4, sd4, dump4, rxl4, rxr4};
            total++;
            if (got !== 58'd0) begin
                bad++; $display("FAIL midreset_outputs i=%0d got=%h exp=0", i, got);
            end
        end
        @(posedge clk);
        #1;
        rst_n4 = 1'b1;
        w2l = $urandom; w2r = $urandom;
        tx_l4 = w2l; tx_r4 = w2r;
        exp_rl = 24'd0;
        exp_rr = 24'd0;
        for (int c = 0; c < 300; c++) begin
            #1;
            e_load = (c % 256) == 0;
            e_dump = (c == 227);
            if (e_dump) begin
                exp_rl = w2l; exp_rr = w2r;
            end
            total++;
            if (load4 !== e_load) begin
                bad++; $display("FAIL midreset_load c=%0d got=%b exp=%b", c, load4, e_load);
            end
            total++;
            if (dump4 !== e_dump) begin
                bad++; $display("FAIL midreset_dump c=%0d got=%b exp=%b", c, dump4, e_dump);
            end
            total++;
            if ({rxl4, rxr4} !== {exp_rl, exp_rr}) begin
                bad++; $display("FAIL midreset_words c=%0d got=%h/%h exp=%h/%h",
                                c, rxl4, rxr4, exp_rl, exp_rr);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_clkdiv8(input int ncyc);
        logic [23:0] fl [0:15];
        logic [23:0] fr [0:15];
        logic [23:0] exp_rl, exp_rr;
        logic        e_sck, e_ws, e_load, e_dump, e_sd;
        int          f;
        exp_rl = 24'd0;
        exp_rr = 24'd0;
        tx_l8 = $urandom; tx_r8 = $urandom;
        rst_n8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n8 = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                tx_l8 = $urandom; tx_r8 = $urandom;
            end
            f = c / 512;
            if (c % 512 == 0) begin
                fl[f] = tx_l8;
                fr[f] = tx_r8;
            end
            #1;
            e_sck  = (c % 8) >= 4;
            e_ws   = ((c / 8) % 64) >= 32;
            e_load = (c % 512) == 0;
            e_dump = (c % 512) == 453;
            e_sd   = model_sd(8, c, fl[f], fr[f]);
            if (e_dump) begin
                exp_rl = fl[f]; exp_rr = fr[f];
            end
            total++;
            if ({sck8, ws8, load8, sd8, dump8} !== {e_sck, e_ws, e_load, e_sd, e_dump}) begin
                bad++; $display("FAIL div8_ctrl c=%0d got sck/ws/load/sd/dump=%b exp=%b", c,
                                {sck8, ws8, load8, sd8, dump8}, {e_sck, e_ws, e_load, e_sd, e_dump});
            end
            total++;
            if ({rxl8, rxr8} !== {exp_rl, exp_rr}) begin
                bad++; $display("FAIL div8_words c=%0d got=%h/%h exp=%h/%h",
                                c, rxl8, rxr8, exp_rl, exp_rr);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n4 = 1'b0; rst_n8 = 1'b0;
        tx_l4 = 24'd0; tx_r4 = 24'd0; tx_l8 = 24'd0; tx_r8 = 24'd0;
        test_reset();
        test_stream(1500, 0);
        test_stream(600, 1);
        test_stream(1100, 2);
        test_reset_midframe();
        test_clkdiv8(1100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
